// File: rtl/tia_horizontal_sync_ctrl_pkg.sv
// Shared constants, decode record and decode helper for the TIA horizontal sync controller.
// Optional LFSR alignment checking is enabled with macro TIA_HSYNC_CHECK_EN.
package tia_horizontal_pkg;

  localparam int unsigned H_PERIOD_CLKS    = 32'd4;
  localparam logic [5:0]  H_LAST_INDEX     = 6'd56;
  localparam int unsigned H_LINE_CLKS      = 32'd228;
  localparam logic [5:0]  HS_START_DEF     = 6'd4;
  localparam logic [5:0]  HS_END_DEF       = 6'd8;
  localparam logic [5:0]  CB_END_DEF       = 6'd12;
  localparam logic [5:0]  HB_END_DEF       = 6'd16;
  localparam logic [5:0]  HB_END_HMOVE_DEF = 6'd18;
  localparam logic [5:0]  LFSR_ZERO        = 6'b000000;

  typedef struct packed {
    logic hsync;
    logic cburst;
    logic hblank;
  } hdecode_t;

  function automatic hdecode_t hdecode(input logic [5:0] hpos,
                                       input logic [5:0] hs_start,
                                       input logic [5:0] hs_end,
                                       input logic [5:0] cb_end,
                                       input logic [5:0] hb_end);
    hdecode_t d;
    d.hsync  = (hpos >= hs_start) && (hpos < hs_end);
    d.cburst = (hpos >= hs_end) && (hpos < cb_end);
    d.hblank = (hpos < hb_end);
    return d;
  endfunction

endpackage

// File: rtl/tia_horizontal_sync_ctrl_if.sv
// Strobe/status bundle between the register-write decoder (master) and the sync controller (slave).
interface tia_horizontal_sync_ctrl_if;

  logic [5:0] lfsr_out;
  logic       wsync;
  logic       rsync;
  logic       hmove;
  logic       rsyn;
  logic       hsync;
  logic       hblank;
  logic       cburst;
  logic       rdy;
  logic [5:0] hpos;
  logic       line_start;
  logic       sync_err;

  modport master (
    output lfsr_out, wsync, rsync, hmove,
    input  rsyn, hsync, hblank, cburst, rdy, hpos, line_start, sync_err
  );

  modport slave (
    input  lfsr_out, wsync, rsync, hmove,
    output rsyn, hsync, hblank, cburst, rdy, hpos, line_start, sync_err
  );

endinterface

// File: rtl/tia_horizontal_sync_ctrl_hphase_counter.sv
// Phase (0..3) and line-index (0..56) counters with wrap and rsync restart.
// The phase output exists only when TIA_HSYNC_CHECK_EN is defined.
module tia_hphase_counter
  import tia_horizontal_pkg::*;
(
  input  logic       clk,
  input  logic       rl,
  input  logic       i_rsync,
  output logic       o_tick,
  output logic [5:0] o_hpos,
  output logic [5:0] o_hpos_nxt,
  output logic       o_line_start,
  output logic       o_line_start_nxt
`ifdef TIA_HSYNC_CHECK_EN
  ,
  output logic [1:0] o_phase
`endif
);

  logic [1:0] r_phase;
  logic [1:0] w_phase_nxt;
  logic [5:0] r_hpos;
  logic [5:0] w_hpos_nxt;
  logic       r_line_start;
  logic       w_line_start_nxt;
  logic       w_tick;
  logic       w_wrap;

  // Next-state: an rsync restart takes priority over the natural wrap
  always_comb begin
    w_tick           = (r_phase == 2'd3);
    w_wrap           = w_tick && (r_hpos == H_LAST_INDEX);
    w_phase_nxt      = r_phase + 2'd1;
    w_hpos_nxt       = r_hpos;
    w_line_start_nxt = w_wrap;
    if (i_rsync) begin
      w_phase_nxt      = 2'd0;
      w_hpos_nxt       = 6'd0;
      w_line_start_nxt = 1'b1;
    end else if (w_wrap) begin
      w_hpos_nxt = 6'd0;
    end else if (w_tick) begin
      w_hpos_nxt = r_hpos + 6'd1;
    end else begin
      w_hpos_nxt = r_hpos;
    end
  end

  // Counter state registers
  always_ff @(posedge clk or negedge rl) begin
    if (!rl) begin
      r_phase      <= 2'd0;
      r_hpos       <= 6'd0;
      r_line_start <= 1'b0;
    end else begin
      r_phase      <= w_phase_nxt;
      r_hpos       <= w_hpos_nxt;
      r_line_start <= w_line_start_nxt;
    end
  end

  assign o_tick           = w_tick;
  assign o_hpos           = r_hpos;
  assign o_hpos_nxt       = w_hpos_nxt;
  assign o_line_start     = r_line_start;
  assign o_line_start_nxt = w_line_start_nxt;
`ifdef TIA_HSYNC_CHECK_EN
  assign o_phase          = r_phase;
`endif

endmodule

// File: rtl/tia_horizontal_sync_ctrl.sv
// TIA horizontal sequencer: line decode, rsyn alignment reset, WSYNC stall and HMOVE blank extension.
// Define TIA_HSYNC_CHECK_EN to build the sticky LFSR misalignment flag.
module tia_horizontal_sync_ctrl
  import tia_horizontal_pkg::*;
#(
  parameter logic [5:0] HS_START     = HS_START_DEF,
  parameter logic [5:0] HS_END       = HS_END_DEF,
  parameter logic [5:0] CB_END       = CB_END_DEF,
  parameter logic [5:0] HB_END       = HB_END_DEF,
  parameter logic [5:0] HB_END_HMOVE = HB_END_HMOVE_DEF
) (
  input  logic                          clk,
  input  logic                          rl,
  tia_horizontal_sync_ctrl_if.slave     hif
);

  logic       w_tick;
  logic [5:0] w_hpos;
  logic [5:0] w_hpos_nxt;
  logic       w_line_start;
  logic       w_line_start_nxt;
  logic       w_hmove_pend_nxt;
  logic       w_rsyn_nxt;
  logic       w_rdy_nxt;
  hdecode_t   w_dec;

  logic       r_hsync;
  logic       r_cburst;
  logic       r_hblank;
  logic       r_rsyn;
  logic       r_rdy;
  logic       r_rs_hold;
  logic       r_hmove_pend;

`ifdef TIA_HSYNC_CHECK_EN
  logic [1:0] w_phase;
  logic       r_sync_err;
`endif

  tia_hphase_counter u_cnt (
    .clk              (clk),
    .rl               (rl),
    .i_rsync          (hif.rsync),
    .o_tick           (w_tick),
    .o_hpos           (w_hpos),
    .o_hpos_nxt       (w_hpos_nxt),
    .o_line_start     (w_line_start),
    .o_line_start_nxt (w_line_start_nxt)
`ifdef TIA_HSYNC_CHECK_EN
    ,
    .o_phase          (w_phase)
`endif
  );

  // Decode from next-state position; a fresh hmove wins over the line-start clear
  always_comb begin
    w_hmove_pend_nxt = hif.hmove | (r_hmove_pend & ~w_line_start_nxt);
    w_dec            = hdecode(w_hpos_nxt, HS_START, HS_END, CB_END,
                               w_hmove_pend_nxt ? HB_END_HMOVE : HB_END);
    w_rsyn_nxt       = (w_hpos_nxt == H_LAST_INDEX) | hif.rsync | (r_rs_hold & ~w_tick);
    if (hif.wsync) begin
      w_rdy_nxt = 1'b0;
    end else if (w_line_start_nxt) begin
      w_rdy_nxt = 1'b1;
    end else begin
      w_rdy_nxt = r_rdy;
    end
  end

  // Registered outputs; r_rs_hold stretches rsyn over the first period after rsync
  always_ff @(posedge clk or negedge rl) begin
    if (!rl) begin
      r_hsync      <= 1'b0;
      r_cburst     <= 1'b0;
      r_hblank     <= 1'b1;
      r_rsyn       <= 1'b1;
      r_rdy        <= 1'b1;
      r_rs_hold    <= 1'b0;
      r_hmove_pend <= 1'b0;
    end else begin
      r_hsync      <= w_dec.hsync;
      r_cburst     <= w_dec.cburst;
      r_hblank     <= w_dec.hblank;
      r_rsyn       <= w_rsyn_nxt;
      r_rdy        <= w_rdy_nxt;
      r_rs_hold    <= hif.rsync | (r_rs_hold & ~w_tick);
      r_hmove_pend <= w_hmove_pend_nxt;
    end
  end

`ifdef TIA_HSYNC_CHECK_EN
  // LFSR must read zero one clk into index 0; flag is sticky until reset
  always_ff @(posedge clk or negedge rl) begin
    if (!rl) begin
      r_sync_err <= 1'b0;
    end else if ((w_hpos == 6'd0) && (w_phase == 2'd1) && (hif.lfsr_out != LFSR_ZERO)) begin
      r_sync_err <= 1'b1;
    end else begin
      r_sync_err <= r_sync_err;
    end
  end
  assign hif.sync_err = r_sync_err;
`else
  assign hif.sync_err = 1'b0;
`endif

  assign hif.hsync      = r_hsync;
  assign hif.cburst     = r_cburst;
  assign hif.hblank     = r_hblank;
  assign hif.rsyn       = r_rsyn;
  assign hif.rdy        = r_rdy;
  assign hif.hpos       = w_hpos;
  assign hif.line_start = w_line_start;

endmodule

// File: tb/tb_tia_horizontal_sync_ctrl.sv
// Bench for tia_horizontal_sync_ctrl: clk-count line model, directed timing pins, then random strobes.
module tb_tia_horizontal_sync_ctrl;

  localparam int LINE = 228;

  typedef struct {
    int k;
    int sig;
    int val;
  } lit_t;

  logic clk = 1'b0;
  logic rl  = 1'b0;
  bit   chk_on = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;
  lit_t lits[$];

  tia_horizontal_sync_ctrl_if hif ();

  tia_horizontal_sync_ctrl dut (
    .clk (clk),
    .rl  (rl),
    .hif (hif)
  );

  always #5 clk = ~clk;

  // Model: m_t = clks since line start (0..227); everything else follows from it
  int m_t;
  int m_rs_left;
  bit m_ls, m_pend, m_rdy, m_err;
  wire m_ls_nxt = hif.rsync || (m_t == LINE - 1);

  always @(posedge clk or negedge rl) begin
    if (!rl) begin
      m_t       <= 0;
      m_ls      <= 1'b0;
      m_pend    <= 1'b0;
      m_rdy     <= 1'b1;
      m_rs_left <= 1;
      m_err     <= 1'b0;
    end else begin
      m_t       <= hif.rsync ? 0 : (m_t + 1) % LINE;
      m_ls      <= m_ls_nxt;
      m_pend    <= hif.hmove || (m_pend && !m_ls_nxt);
      m_rdy     <= !hif.wsync && (m_ls_nxt || m_rdy);
      m_rs_left <= hif.rsync ? 4 : ((m_rs_left > 0) ? m_rs_left - 1 : 0);
`ifdef TIA_HSYNC_CHECK_EN
      if (m_t == 1 && hif.lfsr_out != 6'd0) m_err <= 1'b1;
`endif
    end
  end

  task automatic check(input string nm, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
  endtask

  // Compare process: every clk, away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      int hp;
      hp = m_t / 4;
      check("hpos",       int'(hif.hpos),       hp);
      check("line_start", int'(hif.line_start), int'(m_ls));
      check("hsync",      int'(hif.hsync),      int'(hp >= 4 && hp < 8));
      check("cburst",     int'(hif.cburst),     int'(hp >= 8 && hp < 12));
      check("hblank",     int'(hif.hblank),     int'(hp < (m_pend ? 18 : 16)));
      check("rsyn",       int'(hif.rsyn),       int'(m_rs_left > 0 || hp == 56));
      check("rdy",        int'(hif.rdy),        int'(m_rdy));
      check("sync_err",   int'(hif.sync_err),   int'(m_err));
    end
  end

  function automatic int sigval(input int sel);
    case (sel)
      0: return int'(hif.line_start);
      1: return int'(hif.hsync);
      2: return int'(hif.cburst);
      3: return int'(hif.hblank);
      4: return int'(hif.rsyn);
      5: return int'(hif.rdy);
      6: return int'(hif.hpos);
      default: return int'(hif.sync_err);
    endcase
  endfunction

  task automatic run_lits(input int k);
    foreach (lits[i])
      if (lits[i].k == k) check($sformatf("lit_sig%0d_clk%0d", lits[i].sig, k), sigval(lits[i].sig), lits[i].val);
  endtask

  task automatic cyc(input bit w, input bit r, input bit h, input logic [5:0] lf);
    @(negedge clk);
    hif.wsync = w; hif.rsync = r; hif.hmove = h; hif.lfsr_out = lf;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    hif.wsync = 1'b0; hif.rsync = 1'b0; hif.hmove = 1'b0; hif.lfsr_out = 6'd0;
    #1 rl = 1'b0;
    repeat (2) @(posedge clk);
    #2 rl = 1'b1;
  endtask

  initial begin
    hif.wsync = 1'b0; hif.rsync = 1'b0; hif.hmove = 1'b0; hif.lfsr_out = 6'd0;
    rl = 1'b0;
    repeat (3) @(posedge clk);
    chk_on = 1'b1;
    #1;
    check("rst_hpos", int'(hif.hpos), 0);
    check("rst_rsyn", int'(hif.rsyn), 1);
    check("rst_hblank", int'(hif.hblank), 1);
    check("rst_rdy", int'(hif.rdy), 1);
    @(posedge clk);
    #2 rl = 1'b1;

    // Two lines: wsync at 100 and on the 228 line start, hmove at 20
    lits = '{'{4,6,1}, '{15,1,0}, '{16,1,1}, '{31,1,1}, '{32,1,0}, '{32,2,1}, '{47,2,1},
             '{48,2,0}, '{63,3,1}, '{64,3,1}, '{71,3,1}, '{72,3,0}, '{291,3,1}, '{292,3,0},
             '{223,4,0}, '{224,4,1}, '{227,4,1}, '{228,4,0}, '{100,5,1}, '{101,5,0},
             '{227,5,0}, '{228,5,0}, '{455,5,0}, '{456,5,1}, '{227,0,0}, '{228,0,1},
             '{227,6,56}, '{228,6,0}, '{456,0,1}};
    for (int k = 1; k <= 456; k++) begin
      cyc(k == 101 || k == 228, 1'b0, k == 21, 6'd0);
      run_lits(k);
    end

    // Misaligned LFSR at index 0 phase 1, then rsync at hpos 30
`ifdef TIA_HSYNC_CHECK_EN
    lits = '{'{457,7,0}, '{458,7,1}, '{576,6,30}, '{577,6,0}, '{577,0,1}, '{577,4,1}};
`else
    lits = '{'{458,7,0}, '{576,6,30}, '{577,6,0}, '{577,0,1}, '{577,4,1}};
`endif
    for (int k = 457; k <= 577; k++) begin
      cyc(1'b0, k == 577, 1'b0, (k == 458) ? 6'd1 : 6'd0);
      run_lits(k);
    end
    lits = '{'{580,4,1}, '{581,4,0}, '{804,0,0}, '{805,0,1}, '{965,6,40}, '{965,5,0}};
    for (int k = 578; k <= 965; k++) begin
      cyc(k == 810, 1'b0, 1'b0, 6'd0);
      run_lits(k);
    end

    // Asynchronous reset mid-line while stalled
    #1 rl = 1'b0;
    #1;
    check("arst_hpos", int'(hif.hpos), 0);
    check("arst_rdy", int'(hif.rdy), 1);
    check("arst_rsyn", int'(hif.rsyn), 1);
    check("arst_hblank", int'(hif.hblank), 1);
    check("arst_err", int'(hif.sync_err), 0);
    repeat (2) @(posedge clk);
    #2 rl = 1'b1;
    lits = '{'{1,4,0}, '{16,1,1}, '{224,4,1}, '{227,0,0}, '{228,0,1}};
    for (int k = 1; k <= 228; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 6'd0);
      run_lits(k);
    end

    // Random strobes, LFSR noise and occasional resets
    for (int k = 0; k < 6000; k++) begin
      cyc(($urandom % 40) == 0, ($urandom % 300) == 0, ($urandom % 30) == 0,
          (($urandom % 64) == 0) ? 6'($urandom) : 6'd0);
      if (($urandom % 1500) == 0) do_reset();
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tia_horizontal_sync_ctrl.md
Name: tia_horizontal_sync_ctrl

Overview:
Sequencer for the TIA horizontal counter chain. Divides the colour clock into horizontal-counter periods and tracks line position 0..56. Generates the rsyn reset that keeps the biphase clock and horizontal LFSR aligned, decodes HSYNC/HBLANK/colour-burst windows, and handles the WSYNC (CPU RDY stall) and RSYNC (counter reset) strobes. Sits between the register-write decoder and the tia_biphase_clock / tia_horizontal_lfsr pair.

Parameters:
HS_START, 4, index where hsync rises
HS_END, 8, index where hsync falls
CB_END, 12, index where cburst falls; cburst rises at HS_END
HB_END, 16, index where hblank falls when no HMOVE is pending
HB_END_HMOVE, 18, index where hblank falls after an HMOVE strobe this line

Ports:
clk  in  1  colour clock; single clock domain
rl  in  1  asynchronous active-low reset
lfsr_out  in  6  horizontal LFSR state, used for the alignment check
wsync  in  1  one-clk strobe: stall CPU until the next line start
rsync  in  1  one-clk strobe: restart the line
hmove  in  1  one-clk strobe: extend hblank on the current line
rsyn  out  1  reset to biphase clock/LFSR, active high
hsync  out  1  horizontal sync
hblank  out  1  horizontal blank
cburst  out  1  colour-burst window
rdy  out  1  CPU ready; low = stalled
hpos  out  6  current line index 0..56
line_start  out  1  one-clk pulse on the first clk of index 0
sync_err  out  1  sticky LFSR misalignment flag (optional feature)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. All outputs are registered.
- Reset values (rl low): phase=0, hpos=0, rsyn=1, hblank=1, hsync=0, cburst=0, rdy=1, line_start=0, hmove_pend=0, sync_err=0. The first clk edge after rl rises loads the normal decode, so rsyn drops to 0.
- Phase counter: 2 bits, 0..3, increments every clk. tick = (phase==3).
- hpos:
  - On tick, hpos==56 wraps to 0; otherwise hpos increments.
  - A period is always 4 clks, so a line is 57*4 = 228 clks.
  - line_start is high on the clk where hpos becomes 0 by wrap or by rsync.
- rsyn: high for the whole period of hpos==56 (4 clks). Also high for the 4 clks that follow an rsync strobe.
- rsync strobe: on the next clk, phase=0, hpos=0, line_start=1, rsyn=1 for 4 clks. rsync overrides a wrap on the same clk.
- Decode, evaluated from the next-state hpos with output registered:
  - hsync = HS_START <= hpos < HS_END
  - cburst = HS_END <= hpos < CB_END
  - hblank = hpos < (hmove_pend ? HB_END_HMOVE : HB_END)
- hmove: sets hmove_pend. hmove_pend clears on line_start.
  - An hmove on the same clk as line_start applies to the new line (set wins).
  - An hmove while hpos >= HB_END_HMOVE has no visible effect on that line.
- WSYNC/RDY:
  - wsync drives rdy=0 on the next clk.
  - rdy returns to 1 on the line_start clk.
  - A wsync on the line_start clk keeps rdy=0 until the following line start (wsync wins).
  - A repeated wsync while stalled has no further effect.
  - rsync releases rdy through its line_start.
- Reset mid-line: all state returns to reset values immediately, asynchronously. The line restarts at index 0 after release.

Optional Feature:
Macro TIA_HSYNC_CHECK_EN.
- Defined: on the clk with hpos==0 and phase==1, if lfsr_out != 6'b000000 then sync_err is set. sync_err clears only on rl.
- Undefined: the comparator is not built, sync_err is tied to 0, and lfsr_out is unused.

Decomposition:
- Package tia_horizontal_pkg holds:
  - H_PERIOD_CLKS = 4
  - H_LAST_INDEX = 56
  - H_LINE_CLKS = 228
  - default decode indices (4/8/12/16/18)
  - LFSR_ZERO = 6'b000000
- One sub-module, tia_hphase_counter, contains the phase and hpos counters and the wrap/rsync restart. It outputs tick, hpos and line_start.
- Decode, RDY and hmove logic stay in the top module.

Test Plan:
- Release reset, run 456 clks -> line_start pulses at clk 228 and 456. hsync is high for clks 16..31 of each line, cburst for 32..47, hblank for 0..63. rsyn is high for clks 224..227.
- wsync pulse at clk 100 -> rdy=0 from clk 101 through clk 227, and rdy=1 at clk 228. wsync on clk 228 -> rdy stays 0 until clk 456.
- hmove pulse at clk 20 -> hblank falls at clk 72 (index 18), not 64. On the next line hblank falls at clk 64 again.
- rsync pulse at hpos=30 -> next clk hpos=0, line_start=1, rsyn high for 4 clks. The following line_start comes 228 clks later.
- Assert rl at hpos=40 with rdy=0 -> asynchronously hpos=0, rdy=1, rsyn=1, hblank=1. After release, timing matches the first scenario.
- With TIA_HSYNC_CHECK_EN, force lfsr_out=6'b000001 at index 0, phase 1 -> sync_err=1, held until rl. With lfsr_out=0 the flag stays 0 over 2 lines.
